// File: rtl/fsb_term.sv
// 68000 front-side-bus cycle terminator. It has per-region wait states, an optional
// external ready, autovector acknowledge and a bus-error timeout.
module fsb_term #(
  parameter int NREG      = 4,
  parameter int WSW       = 3,
  parameter int TOW       = 8,
  parameter int TO_CYCLES = 200
) (
  input  logic                FCLK,
  input  logic                RES,
  input  logic                nAS_FSB,
  input  logic                IACS,
  input  logic [NREG-1:0]     CS,
  input  logic [NREG*WSW-1:0] WSCNT,
  input  logic [NREG-1:0]     EXTEN,
  input  logic [NREG-1:0]     Ready,
  output logic                nDTACK_FSB,
  output logic                nVPA_FSB,
  output logic                nBERR_FSB,
  output logic                BACT,
  output logic [3:1]          BACTr,
  output logic                WS
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    TERM = 2'd2,
    BERR = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             as_q;
  logic [3:1]       bactr_q;
  logic             iacs_q, iacs_d;
  logic             hit_q, hit_d;
  logic             exten_q, exten_d;
  logic [RW-1:0]    region_q, region_d;
  logic [WSW-1:0]   wcnt_q, wcnt_d;
  logic [TOW-1:0]   tcnt_q, tcnt_d;
  logic             ndtack_q, ndtack_d;
  logic             nvpa_q, nvpa_d;
  logic             nberr_q, nberr_d;
  logic             ws_q, ws_d;

  logic [RW-1:0]    selIdx;
  logic             selHit;
  logic             termOk;

  // Lowest-numbered asserted chip select wins when regions overlap.
  always_comb begin
    selIdx = '0;
    selHit = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (CS[i]) begin
        selIdx = RW'(i);
        selHit = 1'b1;
      end
    end
  end

  assign termOk = iacs_q ||
                  (hit_q && (wcnt_q == '0) && (!exten_q || Ready[region_q]));

  always_comb begin
    state_d  = state_q;
    iacs_d   = iacs_q;
    hit_d    = hit_q;
    exten_d  = exten_q;
    region_d = region_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;

    unique case (state_q)
      IDLE: begin
        if (as_q && !bactr_q[1]) begin
          iacs_d   = IACS;
          hit_d    = selHit;
          region_d = selIdx;
          exten_d  = EXTEN[selIdx];
          wcnt_d   = (IACS || !selHit) ? '0 : WSCNT[selIdx*WSW +: WSW];
          tcnt_d   = '0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (!as_q) begin
          state_d = IDLE;
        end else if (termOk) begin
          state_d = TERM;
        end else if (tcnt_q == TO_LAST) begin
          state_d = BERR;
        end else begin
          wcnt_d = (wcnt_q != '0) ? wcnt_q - WSW'(1) : '0;
          tcnt_d = tcnt_q + TOW'(1);
        end
      end
      TERM: begin
        if (!as_q) state_d = IDLE;
      end
      BERR: begin
        if (!as_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are derived from the next state so the pins come straight off flops.
    ws_d     = (state_d == WAIT);
    ndtack_d = !((state_d == TERM) && !iacs_d);
    nvpa_d   = !((state_d == TERM) && iacs_d);
    nberr_d  = !(state_d == BERR);
  end

  always_ff @(posedge FCLK) begin
    if (RES) begin
      state_q  <= IDLE;
      as_q     <= 1'b0;
      bactr_q  <= '0;
      iacs_q   <= 1'b0;
      hit_q    <= 1'b0;
      exten_q  <= 1'b0;
      region_q <= '0;
      wcnt_q   <= '0;
      tcnt_q   <= '0;
      ndtack_q <= 1'b1;
      nvpa_q   <= 1'b1;
      nberr_q  <= 1'b1;
      ws_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      as_q     <= !nAS_FSB;
      bactr_q  <= {bactr_q[2:1], as_q};
      iacs_q   <= iacs_d;
      hit_q    <= hit_d;
      exten_q  <= exten_d;
      region_q <= region_d;
      wcnt_q   <= wcnt_d;
      tcnt_q   <= tcnt_d;
      ndtack_q <= ndtack_d;
      nvpa_q   <= nvpa_d;
      nberr_q  <= nberr_d;
      ws_q     <= ws_d;
    end
  end

  assign BACT       = as_q;
  assign BACTr      = bactr_q;
  assign WS         = ws_q;
  assign nDTACK_FSB = ndtack_q;
  assign nVPA_FSB   = nvpa_q;
  assign nBERR_FSB  = nberr_q;

endmodule

// File: tb/tb_fsb_term.sv
// Directed bench for fsb_term: each step lists the edge at which the strobes are expected
// to move, and the expected values are worked out by hand from the bus timing.
module tb_fsb_term;

  logic        FCLK = 1'b0;
  logic        RES;
  logic        nAS_FSB;
  logic        IACS;
  logic [3:0]  CS;
  logic [11:0] WSCNT;
  logic [3:0]  EXTEN;
  logic [3:0]  Ready;
  logic        nDTACK_FSB;
  logic        nVPA_FSB;
  logic        nBERR_FSB;
  logic        BACT;
  logic [3:1]  BACTr;
  logic        WS;

  int compareCount = 0;
  int failCount    = 0;

  fsb_term #(.NREG(4), .WSW(3), .TOW(8), .TO_CYCLES(200)) dut (
    .FCLK(FCLK), .RES(RES), .nAS_FSB(nAS_FSB), .IACS(IACS), .CS(CS),
    .WSCNT(WSCNT), .EXTEN(EXTEN), .Ready(Ready),
    .nDTACK_FSB(nDTACK_FSB), .nVPA_FSB(nVPA_FSB), .nBERR_FSB(nBERR_FSB),
    .BACT(BACT), .BACTr(BACTr), .WS(WS)
  );

  always #5 FCLK = ~FCLK;

  // One rising edge, then settle 1 ns so outputs are sampled away from the edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge FCLK);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkStrobes(input string tag, input logic dtack, input logic vpa, input logic berr);
    checkOutput(tag, {5'd0, nDTACK_FSB, nVPA_FSB, nBERR_FSB}, {5'd0, dtack, vpa, berr});
  endtask

  // Drives nAS low and returns just after edge 0, where BACT first reads 1.
  task automatic startCycle();
    nAS_FSB = 1'b0;
    tick();
  endtask

  // Releases nAS and lets the terminator return to IDLE.
  task automatic endCycle();
    nAS_FSB = 1'b1;
    tick(3);
  endtask

  initial begin
    RES = 1'b1; nAS_FSB = 1'b0; IACS = 1'b0; CS = 4'b0001;
    WSCNT = 12'd0; EXTEN = 4'd0; Ready = 4'd0;

    // Reset held with nAS low, then a cycle already in progress is accepted as new.
    tick(3);
    checkStrobes("reset strobes", 1'b1, 1'b1, 1'b1);
    checkOutput("reset BACT", {7'd0, BACT}, 8'd0);
    checkOutput("reset BACTr", {5'd0, BACTr}, 8'd0);
    checkOutput("reset WS", {7'd0, WS}, 8'd0);
    RES = 1'b0;
    tick();
    checkOutput("post-reset BACT", {7'd0, BACT}, 8'd1);
    checkOutput("post-reset WS e0", {7'd0, WS}, 8'd0);
    tick();
    checkOutput("post-reset WS e1", {7'd0, WS}, 8'd1);
    tick();
    checkStrobes("post-reset dtack e2", 1'b0, 1'b1, 1'b1);
    endCycle();
    checkStrobes("post-reset release", 1'b1, 1'b1, 1'b1);
    checkOutput("post-reset idle WS", {7'd0, WS}, 8'd0);

    // Region 1 with 3 wait states; selects change after entry and must be ignored.
    CS = 4'b0010; WSCNT = 12'b000_000_011_000;
    startCycle();
    tick();
    CS = 4'b0000; WSCNT = 12'd0;
    checkOutput("ws3 WS e1", {7'd0, WS}, 8'd1);
    tick(3);
    checkStrobes("ws3 e4", 1'b1, 1'b1, 1'b1);
    tick();
    checkStrobes("ws3 e5", 1'b0, 1'b1, 1'b1);
    tick(3);
    nAS_FSB = 1'b1;
    tick();
    checkStrobes("ws3 e9 held", 1'b0, 1'b1, 1'b1);
    checkOutput("ws3 e9 BACT", {7'd0, BACT}, 8'd0);
    tick();
    checkStrobes("ws3 e10 release", 1'b1, 1'b1, 1'b1);
    tick(2);

    // External ready on region 0, 1 wait state, Ready arrives before edge 6.
    CS = 4'b0001; WSCNT = 12'b000_000_000_001; EXTEN = 4'b0001; Ready = 4'b0000;
    startCycle();
    tick(5);
    checkStrobes("extrdy e5", 1'b1, 1'b1, 1'b1);
    Ready = 4'b0001;
    tick();
    checkStrobes("extrdy e6", 1'b0, 1'b1, 1'b1);
    endCycle();

    // Same region with Ready high throughout: wait states alone set the timing.
    startCycle();
    tick(2);
    checkStrobes("rdyhigh e2", 1'b1, 1'b1, 1'b1);
    tick();
    checkStrobes("rdyhigh e3", 1'b0, 1'b1, 1'b1);
    endCycle();
    EXTEN = 4'd0; Ready = 4'd0;

    // Overlapping selects: region 2 (2 waits) beats region 3 (5 waits).
    CS = 4'b1100; WSCNT = 12'b101_010_111_111;
    startCycle();
    tick(3);
    checkStrobes("prio e3", 1'b1, 1'b1, 1'b1);
    tick();
    checkStrobes("prio e4", 1'b0, 1'b1, 1'b1);
    endCycle();

    // Interrupt acknowledge with no region selected: autovector after minimum latency.
    CS = 4'b0000; IACS = 1'b1;
    startCycle();
    tick();
    checkStrobes("iack e1", 1'b1, 1'b1, 1'b1);
    tick();
    checkStrobes("iack e2", 1'b1, 1'b0, 1'b1);
    endCycle();
    checkStrobes("iack release", 1'b1, 1'b1, 1'b1);
    IACS = 1'b0;

    // Unmapped cycle times out into a bus error at edge 201.
    CS = 4'b0000;
    startCycle();
    tick(200);
    checkStrobes("timeout e200", 1'b1, 1'b1, 1'b1);
    tick();
    checkStrobes("timeout e201", 1'b1, 1'b1, 1'b0);
    nAS_FSB = 1'b1;
    tick();
    checkStrobes("timeout held", 1'b1, 1'b1, 1'b0);
    tick();
    checkStrobes("timeout release", 1'b1, 1'b1, 1'b1);
    tick(2);

    // Ready first seen on the timeout edge: termination takes priority.
    CS = 4'b0001; WSCNT = 12'd0; EXTEN = 4'b0001; Ready = 4'b0000;
    startCycle();
    tick(200);
    checkStrobes("race e200", 1'b1, 1'b1, 1'b1);
    Ready = 4'b0001;
    tick();
    checkStrobes("race e201", 1'b0, 1'b1, 1'b1);
    endCycle();
    EXTEN = 4'd0; Ready = 4'd0;

    // Abort during a long wait, then a normal cycle.
    CS = 4'b0001; WSCNT = 12'b000_000_000_111;
    startCycle();
    tick(2);
    nAS_FSB = 1'b1;
    tick();
    checkOutput("abort e3 WS", {7'd0, WS}, 8'd1);
    tick();
    checkOutput("abort e4 WS", {7'd0, WS}, 8'd0);
    tick(8);
    checkStrobes("abort quiet", 1'b1, 1'b1, 1'b1);
    WSCNT = 12'd0;
    startCycle();
    tick(2);
    checkStrobes("after abort e2", 1'b0, 1'b1, 1'b1);
    endCycle();

    // Reset asserted while terminating, then released with nAS still low.
    startCycle();
    tick(2);
    RES = 1'b1;
    tick();
    checkStrobes("midreset strobes", 1'b1, 1'b1, 1'b1);
    checkOutput("midreset BACT", {4'd0, BACTr, BACT}, 8'd0);
    checkOutput("midreset WS", {7'd0, WS}, 8'd0);
    RES = 1'b0;
    tick(2);
    checkStrobes("midreset e1", 1'b1, 1'b1, 1'b1);
    tick();
    checkStrobes("midreset e2", 1'b0, 1'b1, 1'b1);
    endCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/fsb_term.md
# fsb_term

Parametrised front-side-bus cycle terminator for the MC68HC000 FSB. It supersedes the fixed-function termination logic by supporting NREG chip-select regions, each with a programmable wait-state count and an optional external-ready qualifier. It adds autovector (VPA) termination for interrupt acknowledge and a bus-error timeout for unmapped or hung cycles. It sits between the chip-select decoder and the 68000 `nDTACK_FSB` / `nVPA_FSB` / `nBERR_FSB` pins, and exports the AS-cycle detection signals consumed by the RAM and QoS logic.

## Interface
- NREG, 4, number of chip-select regions
- WSW, 3, width of each per-region wait-state field
- TOW, 8, width of the timeout counter
- TO_CYCLES, 200, FCLK cycles spent in WAIT before bus error (1..2^TOW-1)

- FCLK  in  1  FSB clock; all state changes on its rising edge
- RES  in  1  synchronous active-high reset
- nAS_FSB  in  1  68000 address strobe, active low
- IACS  in  1  interrupt-acknowledge select (autovector request)
- CS  in  NREG  region selects; lowest set bit wins
- WSCNT  in  NREG*WSW  wait states per region; field r is bits [r*WSW +: WSW]
- EXTEN  in  NREG  region r additionally requires Ready[r]
- Ready  in  NREG  external ready per region
- nDTACK_FSB  out  1  data acknowledge, active low
- nVPA_FSB  out  1  valid peripheral address (autovector), active low
- nBERR_FSB  out  1  bus error, active low
- BACT  out  1  registered bus-active (`!nAS_FSB` sampled)
- BACTr  out  3  BACT delayed 1, 2 and 3 cycles ([1] = 1-cycle delay)
- WS  out  1  high while in WAIT

## Operation
- ASr register samples `!nAS_FSB` every edge, so BACT = ASr. BACTr shifts BACT.
- States: IDLE, WAIT, TERM, BERR.
- IDLE, BACT=1 with BACTr[1]=0 (new cycle):
  - latch IACS, region index r (lowest set CS bit) and a hit flag (any CS set);
  - load wcnt = WSCNT[r], or 0 when IACS or no hit;
  - clear tcnt;
  - go WAIT.
- IDLE, BACT=1 with BACTr[1]=1: stay IDLE. This covers the end of a terminated or aborted cycle.
- WAIT, each edge, first match wins:
  - BACT=0 (abort): go IDLE, no strobe asserted.
  - Terminating condition met: go TERM. The condition is hit and wcnt==0 and (!EXTEN[r] or Ready[r]), or latched IACS.
  - tcnt == TO_CYCLES-1: go BERR. This covers unmapped regions and Ready that never arrives.
  - Otherwise: wcnt decrements (saturates at 0) and tcnt increments.
- Termination beats timeout on the same edge.
- TERM: assert nVPA_FSB if IACS was latched, else nDTACK_FSB. Hold until BACT=0, then go IDLE.
- BERR: assert nBERR_FSB. Hold until BACT=0, then go IDLE.
- CS, WSCNT, EXTEN and IACS are ignored after WAIT entry. Ready is sampled only in WAIT.
- At most one of nDTACK_FSB, nVPA_FSB and nBERR_FSB is low at any time.
- Reset values:
  - state = IDLE, wcnt = 0, tcnt = 0;
  - BACT = 0, BACTr = 0, WS = 0;
  - nDTACK_FSB = 1, nVPA_FSB = 1, nBERR_FSB = 1.
- RES asserted mid-cycle (any state) returns all of the above to reset values on that edge.
- After reset, a cycle already in progress (BACT immediately 1) is treated as new only if BACTr[1]=0. This holds because BACTr is also cleared.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Edge 0: nAS_FSB sampled low, BACT=1.
- Edge 1: WAIT entered, WS=1.
- Internal region with WSCNT=n: strobe low from edge 2+n.
- Minimum latency (n=0, or IACS) is 2 FCLK cycles from the AS-sampled edge.
- EXTEN region: strobe low on the first edge ≥ 2+n at which Ready was sampled high in WAIT.
- Timeout: nBERR_FSB low at edge 1+TO_CYCLES when no termination occurs.
- Strobe release: the edge after nAS_FSB is sampled high. That sampling edge sets BACT=0; the next edge sets state IDLE and the strobe high. The strobe therefore deasserts 2 edges after nAS rises at the pin.
- Back-to-back cycles: a new cycle is accepted only after BACT=0 for at least one edge, which the 68000 guarantees.
- Counter widths: wcnt is WSW bits; tcnt is TOW bits and never wraps, because the comparison fires at TO_CYCLES-1.

## Test plan
- Reset: hold RES=1 for 3 edges while nAS_FSB=0 → all three strobes 1, BACT=0, WS=0. Release → new cycle accepted at BACTr[1]=0.
- Wait states: CS=0b0010, WSCNT[1]=3, EXTEN=0, nAS low at edge 0 → nDTACK_FSB low at edge 5. Raise nAS at edge 8 → nDTACK_FSB high at edge 10.
- External ready: CS=0b0001, WSCNT[0]=1, EXTEN[0]=1, Ready[0] rises before edge 6 → nDTACK_FSB low at edge 6 (not 3). Repeat with Ready high throughout → low at edge 3.
- Priority/autovector: CS=0b1100 → region 2 timing used. IACS=1 with CS=0 → nVPA_FSB low at edge 2, nDTACK_FSB stays 1.
- Timeout: CS=0, TO_CYCLES=200 → nBERR_FSB low at edge 201. Also Ready[0] first high at the timeout edge (with EXTEN[0]=1) → nDTACK_FSB wins, nBERR_FSB stays 1.
- Abort: nAS_FSB rises during WAIT (WSCNT=7) → IDLE, no strobe asserted. The next cycle terminates normally.
